// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch stage and its consumers.
//   fetch_state_t : fetch FSM states (RUN = skid empty, STALLED = skid holds a response)
//   PC_STEP       : byte increment between sequential instructions
//   ifid_t        : IF/ID boundary record {pc, instr, valid} at the default 32-bit widths,
//                   for decode-side code that wants the record as a single struct
package fetch_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        STALLED = 1'b1
    } fetch_state_t;

    localparam int unsigned PC_STEP     = 4;
    localparam int unsigned IFID_PC_W   = 32;
    localparam int unsigned IFID_DATA_W = 32;

    typedef struct packed {
        logic [IFID_PC_W-1:0]   pc;
        logic [IFID_DATA_W-1:0] instr;
        logic                   valid;
    } ifid_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// fetch_skid_buffer: one-entry holding register for an IF/ID record that arrives
// while decode is stalled.
//   i_clk   in   rising-edge clock
//   i_rst   in   synchronous active-high reset (empties and zeroes the entry)
//   i_load  in   capture i_data, mark full
//   i_clear in   empty the entry (wins over i_load)
//   i_data  in   WIDTH-bit packed record to capture
//   o_data  out  held record
//   o_full  out  entry holds a captured record
module fetch_skid_buffer #(
    parameter int unsigned WIDTH = 65
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full
);

    logic [WIDTH-1:0] r_data;
    logic             r_full;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_data <= '0;
            r_full <= 1'b0;
        end else if (i_clear) begin
            r_full <= 1'b0;
        end else if (i_load) begin
            r_data <= i_data;
            r_full <= 1'b1;
        end
    end

    assign o_data = r_data;
    assign o_full = r_full;

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage in front of a synchronous-read instruction memory.
// Owns the PC, presents it to imem, and registers {pc, instr, valid} into IF/ID.
// A one-entry skid buffer absorbs the response that lands while decode stalls, so
// no instruction is lost or duplicated. An EX redirect kills all younger fetches.
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   imem_pc      out  byte address presented to imem
//   imem_instr   in   imem data for the address presented the previous cycle
//   stall        in   decode cannot accept; hold IF/ID and PC
//   redirect     in   taken branch / jump from EX
//   redirect_pc  in   redirect target byte address (low two bits ignored)
//   if_id_pc     out  PC of if_id_instr
//   if_id_instr  out  fetched instruction
//   if_id_valid  out  IF/ID holds a valid, correct-path instruction
// Optional: define FETCH_MISALIGN_TRAP_EN to add output fetch_misalign, a registered
// one-cycle pulse following a redirect whose target has nonzero low two bits.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned          DATA_WIDTH = 32,
    parameter int unsigned          PC_WIDTH   = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [PC_WIDTH-1:0]   imem_pc,
    input  logic [DATA_WIDTH-1:0] imem_instr,
    input  logic                  stall,
    input  logic                  redirect,
    input  logic [PC_WIDTH-1:0]   redirect_pc,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic                  fetch_misalign,
`endif
    output logic [PC_WIDTH-1:0]   if_id_pc,
    output logic [DATA_WIDTH-1:0] if_id_instr,
    output logic                  if_id_valid
);

    localparam int unsigned REC_W = PC_WIDTH + DATA_WIDTH + 1;

    fetch_state_t          r_state;
    fetch_state_t          w_state_next;
    logic [PC_WIDTH-1:0]   r_pc;
    logic [PC_WIDTH-1:0]   w_pc_next;
    logic [PC_WIDTH-1:0]   r_rsp_pc;
    logic                  r_rsp_valid;
    logic [PC_WIDTH-1:0]   r_if_id_pc;
    logic [DATA_WIDTH-1:0] r_if_id_instr;
    logic                  r_if_id_valid;

    logic                  w_skid_load;
    logic                  w_skid_clear;
    logic                  w_skid_full;
    logic [REC_W-1:0]      w_rsp_rec;
    logic [REC_W-1:0]      w_skid_rec;
    logic                  w_ifid_from_rsp;
    logic                  w_ifid_from_skid;
    logic                  w_ifid_kill;

    assign w_rsp_rec = {r_rsp_pc, imem_instr, r_rsp_valid};

    fetch_skid_buffer #(
        .WIDTH (REC_W)
    ) u_skid (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_data  (w_rsp_rec),
        .o_data  (w_skid_rec),
        .o_full  (w_skid_full)
    );

    always_comb begin
        w_state_next     = r_state;
        w_pc_next        = r_pc + PC_WIDTH'(PC_STEP);
        w_skid_load      = 1'b0;
        w_skid_clear     = 1'b0;
        w_ifid_from_rsp  = 1'b0;
        w_ifid_from_skid = 1'b0;
        w_ifid_kill      = 1'b0;
        if (redirect) begin
            w_ifid_kill  = 1'b1;
            w_skid_clear = 1'b1;
            w_state_next = RUN;
            w_pc_next    = {redirect_pc[PC_WIDTH-1:2], 2'b00};
        end else begin
            case (r_state)
                RUN: begin
                    if (stall) begin
                        w_skid_load  = 1'b1;
                        w_pc_next    = r_pc;
                        w_state_next = STALLED;
                    end else begin
                        w_ifid_from_rsp = 1'b1;
                    end
                end
                STALLED: begin
                    // While stalled imem keeps re-reading the held PC; that response is
                    // dropped. On release the PC steps past it, so the next response is
                    // exactly the instruction following the skid entry.
                    if (stall) begin
                        w_pc_next = r_pc;
                    end else begin
                        w_ifid_from_skid = 1'b1;
                        w_skid_clear     = 1'b1;
                        w_state_next     = RUN;
                    end
                end
                default: w_state_next = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= RUN;
            r_pc          <= RESET_PC;
            r_rsp_pc      <= '0;
            r_rsp_valid   <= 1'b0;
            r_if_id_pc    <= '0;
            r_if_id_instr <= '0;
            r_if_id_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_pc        <= w_pc_next;
            r_rsp_pc    <= r_pc;
            r_rsp_valid <= !redirect;
            if (w_ifid_kill) begin
                r_if_id_valid <= 1'b0;
            end else if (w_ifid_from_rsp) begin
                {r_if_id_pc, r_if_id_instr, r_if_id_valid} <= w_rsp_rec;
            end else if (w_ifid_from_skid) begin
                r_if_id_pc    <= w_skid_rec[REC_W-1 -: PC_WIDTH];
                r_if_id_instr <= w_skid_rec[DATA_WIDTH:1];
                r_if_id_valid <= w_skid_rec[0] & w_skid_full;
            end
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    logic r_fetch_misalign;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_misalign <= 1'b0;
        end else begin
            r_fetch_misalign <= redirect && (redirect_pc[1:0] != 2'b00);
        end
    end

    assign fetch_misalign = r_fetch_misalign;
`endif

    assign imem_pc     = r_pc;
    assign if_id_pc    = r_if_id_pc;
    assign if_id_instr = r_if_id_instr;
    assign if_id_valid = r_if_id_valid;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed and randomized stimulus for instr_fetch_unit against a
// stream-level reference: which PC decode should see next, how many bubble cycles
// remain after a reset or redirect, and where the fetch PC should be.
// Build with FETCH_MISALIGN_TRAP_EN defined to also check fetch_misalign.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr = '0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fetch_misalign;
`endif

    int n_chk = 0;
    int n_bad = 0;

    // Reference state: fetch PC, PC decode should currently hold, bubble cycles left.
    logic [31:0] m_pc   = '0;
    logic [31:0] m_head = '0;
    int          m_fill = 2;
    logic        m_mis  = 1'b0;

    instr_fetch_unit #(
        .DATA_WIDTH (32),
        .PC_WIDTH   (32),
        .RESET_PC   (32'h0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_pc        (imem_pc),
        .imem_instr     (imem_instr),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
`ifdef FETCH_MISALIGN_TRAP_EN
        .fetch_misalign (fetch_misalign),
`endif
        .if_id_pc       (if_id_pc),
        .if_id_instr    (if_id_instr),
        .if_id_valid    (if_id_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h0100_0193) ^ 32'hA5A5_0013;
    endfunction

    // Synchronous-read instruction memory: data one cycle after the address.
    always @(posedge clk) imem_instr <= memf(imem_pc);

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic s, input logic rd, input logic [31:0] t);
        if (r) begin
            m_pc = 32'h0; m_head = 32'h0; m_fill = 2; m_mis = 1'b0;
        end else if (rd) begin
            m_pc = {t[31:2], 2'b00}; m_head = m_pc; m_fill = 2;
            m_mis = (t[1:0] != 2'b00);
        end else begin
            m_mis = 1'b0;
            if (m_fill > 0) begin
                m_fill--;
                m_pc += 4;
            end else if (!s) begin
                m_head += 4;
                m_pc   += 4;
            end
        end
    endtask

    task automatic check_outputs(input logic r);
        chk("imem_pc", {32'h0, imem_pc}, {32'h0, m_pc});
        chk("valid", {63'h0, if_id_valid}, {63'h0, (m_fill == 0)});
        if (m_fill == 0) begin
            chk("if_id_pc", {32'h0, if_id_pc}, {32'h0, m_head});
            chk("if_id_instr", {32'h0, if_id_instr}, {32'h0, memf(m_head)});
        end
        if (r) begin
            chk("rst_pc", {32'h0, if_id_pc}, 64'h0);
            chk("rst_instr", {32'h0, if_id_instr}, 64'h0);
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("misalign", {63'h0, fetch_misalign}, {63'h0, m_mis});
`endif
    endtask

    // One clock: drive inputs, advance the model at the edge, check on the falling edge.
    // Stall is withheld during post-restart bubbles; decode has nothing to hold then.
    task automatic cyc(input logic r, input logic s, input logic rd, input logic [31:0] t);
        if (!r && !rd && m_fill > 0) s = 1'b0;
        rst = r; stall = s; redirect = rd; redirect_pc = t;
        @(posedge clk);
        model_step(r, s, rd, t);
        @(negedge clk);
        check_outputs(r);
    endtask

    task automatic run_to_head(input logic [31:0] pc);
        int k;
        for (k = 0; k < 40 && !(m_fill == 0 && m_head == pc); k++) cyc(0, 0, 0, 0);
        chk("reach_head", {63'h0, (m_fill == 0 && m_head == pc)}, 64'h1);
    endtask

    initial begin
        @(negedge clk);
        cyc(1, 0, 0, 0);
        cyc(1, 1, 1, 32'h100);

        // Pipeline fill from reset, then stall held three cycles at pc 8.
        run_to_head(32'h8);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);

        // Alternating single-cycle stalls.
        for (int i = 0; i < 10; i++) cyc(0, (i % 2) == 0, 0, 0);

        // Redirect to 0x40 while decode holds pc 12.
        cyc(1, 0, 0, 0);
        run_to_head(32'hC);
        cyc(0, 0, 1, 32'h40);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);

        // Redirect together with stall while STALLED.
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 1, 32'h80);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);

        // Reset in the middle of a stall, then a misaligned redirect.
        cyc(0, 1, 0, 0);
        cyc(1, 1, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 32'h42);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);

        // PC wrap at the top of the address space.
        cyc(0, 0, 1, 32'hFFFF_FFF8);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            cyc($urandom_range(0, 99) == 0,
                $urandom_range(0, 99) < 35,
                $urandom_range(0, 19) == 0,
                $urandom & 32'h0000_0FFF);
        end
        cyc(0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
